// File: rtl/ui_bram_responder.sv
// ui_bram_responder
//   Block-RAM backed stand-in for a MIG 7-series UI (app_*) port. Commands
//   and write beats are queued in two small FIFOs. An in-order execute engine
//   retires one command per cycle from the command FIFO head. Read data comes
//   back RD_LAT cycles after the read executes.
//
//   Optional build macro: UI_BRAM_RANDOM_STALL_EN. When it is defined, a
//   16-bit LFSR injects pseudo-random deassertions of the ready signals.
//
// Ports
//   clk_i, async_rst_i       clock, asynchronous active-high reset
//   app_addr_i/cmd_i/en_i    command channel (000 write, 001 read, else ignored)
//   app_wdf_data/mask/wren/end_i   write-data channel (mask 1 = keep byte)
//   app_rd_data/valid/end_o  read-return channel, no backpressure
//   app_rdy_o, app_wdf_rdy_o command / write-data ready
//   init_calib_complete_o    high INIT_CYC cycles after reset release
module ui_bram_responder #(
    parameter int DW        = 128,
    parameter int AW        = 27,
    parameter int MEM_LOG2  = 10,
    parameter int RD_LAT    = 2,
    parameter int FIFO_LOG2 = 2,
    parameter int INIT_CYC  = 16
) (
    input  logic            clk_i,
    input  logic            async_rst_i,
    input  logic [AW-1:0]   app_addr_i,
    input  logic [2:0]      app_cmd_i,
    input  logic            app_en_i,
    input  logic [DW-1:0]   app_wdf_data_i,
    input  logic [DW/8-1:0] app_wdf_mask_i,
    input  logic            app_wdf_wren_i,
    input  logic            app_wdf_end_i,
    output logic [DW-1:0]   app_rd_data_o,
    output logic            app_rd_data_valid_o,
    output logic            app_rd_data_end_o,
    output logic            app_rdy_o,
    output logic            app_wdf_rdy_o,
    output logic            init_calib_complete_o
);
    localparam int MW    = DW / 8;
    localparam int FD    = 1 << FIFO_LOG2;
    localparam int DEPTH = 1 << MEM_LOG2;
    localparam int CW    = $clog2(INIT_CYC + 1);

    // Storage (no reset: contents are don't-care until a pointer covers them)
    logic [2:0]          cmd_mem  [FD];
    logic [MEM_LOG2-1:0] cadr_mem [FD];
    logic [DW-1:0]       wdat_mem [FD];
    logic [MW-1:0]       wmsk_mem [FD];
    logic [DW-1:0]       ram      [DEPTH];

    // Pointers carry one extra wrap bit to tell full from empty
    logic [FIFO_LOG2:0] cwp_q, cwp_d, crp_q, crp_d;
    logic [FIFO_LOG2:0] wwp_q, wwp_d, wrp_q, wrp_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               calib_q, calib_d;
    logic [RD_LAT:1]           vld_pipe_q, vld_pipe_d;
    logic [RD_LAT:1][DW-1:0]   dat_pipe_q, dat_pipe_d;

    logic                cmd_empty, cmd_full, wdf_empty, wdf_full;
    logic                cmd_push, cmd_pop, wdf_push, exec_wr, exec_rd;
    logic [2:0]          head_cmd;
    logic [MEM_LOG2-1:0] head_idx;
    logic                rdy_stall, wdf_stall;

    logic unused_ok;
    assign unused_ok = ^{app_wdf_end_i, app_addr_i[AW-1:MEM_LOG2+3], app_addr_i[2:0]};

`ifdef UI_BRAM_RANDOM_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;
    always_comb begin
        lfsr_d = lfsr_q;
        // Fibonacci form, taps 16,14,13,11
        if (calib_q) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) lfsr_q <= 16'hACE1;
        else             lfsr_q <= lfsr_d;
    end
    assign rdy_stall = (lfsr_q[1:0] == 2'b00);
    assign wdf_stall = (lfsr_q[3:2] == 2'b00);
`else
    assign rdy_stall = 1'b0;
    assign wdf_stall = 1'b0;
`endif

    // Ready depends only on registered state
    assign app_rdy_o     = calib_q & ~cmd_full & ~rdy_stall;
    assign app_wdf_rdy_o = calib_q & ~wdf_full & ~wdf_stall;

    always_comb begin
        cmd_empty = (cwp_q == crp_q);
        cmd_full  = (cwp_q[FIFO_LOG2] != crp_q[FIFO_LOG2]) &&
                    (cwp_q[FIFO_LOG2-1:0] == crp_q[FIFO_LOG2-1:0]);
        wdf_empty = (wwp_q == wrp_q);
        wdf_full  = (wwp_q[FIFO_LOG2] != wrp_q[FIFO_LOG2]) &&
                    (wwp_q[FIFO_LOG2-1:0] == wrp_q[FIFO_LOG2-1:0]);
        cmd_push  = app_en_i & app_rdy_o;
        wdf_push  = app_wdf_wren_i & app_wdf_rdy_o;
        head_cmd  = cmd_mem[crp_q[FIFO_LOG2-1:0]];
        head_idx  = cadr_mem[crp_q[FIFO_LOG2-1:0]];
        // A write at the head waits for its data beat; everything else retires at once
        exec_wr   = !cmd_empty && (head_cmd == 3'b000) && !wdf_empty;
        exec_rd   = !cmd_empty && (head_cmd == 3'b001);
        cmd_pop   = !cmd_empty && ((head_cmd != 3'b000) || !wdf_empty);
        cwp_d = cwp_q + {{FIFO_LOG2{1'b0}}, cmd_push};
        crp_d = crp_q + {{FIFO_LOG2{1'b0}}, cmd_pop};
        wwp_d = wwp_q + {{FIFO_LOG2{1'b0}}, wdf_push};
        wrp_d = wrp_q + {{FIFO_LOG2{1'b0}}, exec_wr};
    end

    always_comb begin
        cnt_d   = cnt_q;
        calib_d = calib_q;
        if (!calib_q) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(INIT_CYC - 1)) calib_d = 1'b1;
        end
    end

    // Read-return pipeline. Stage 1 captures the RAM word in the execute
    // cycle; a write that executed the previous cycle has already landed in
    // ram, so read-after-write returns new data without a bypass.
    always_comb begin
        vld_pipe_d    = vld_pipe_q;
        dat_pipe_d    = dat_pipe_q;
        vld_pipe_d[1] = exec_rd;
        if (exec_rd) dat_pipe_d[1] = ram[head_idx];
        for (int k = 2; k <= RD_LAT; k++) begin
            vld_pipe_d[k] = vld_pipe_q[k-1];
            dat_pipe_d[k] = dat_pipe_q[k-1];
        end
    end

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            cwp_q      <= '0;
            crp_q      <= '0;
            wwp_q      <= '0;
            wrp_q      <= '0;
            cnt_q      <= '0;
            calib_q    <= 1'b0;
            vld_pipe_q <= '0;
            dat_pipe_q <= '0;
        end else begin
            cwp_q      <= cwp_d;
            crp_q      <= crp_d;
            wwp_q      <= wwp_d;
            wrp_q      <= wrp_d;
            cnt_q      <= cnt_d;
            calib_q    <= calib_d;
            vld_pipe_q <= vld_pipe_d;
            dat_pipe_q <= dat_pipe_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (cmd_push) begin
            cmd_mem[cwp_q[FIFO_LOG2-1:0]]  <= app_cmd_i;
            cadr_mem[cwp_q[FIFO_LOG2-1:0]] <= app_addr_i[MEM_LOG2+2:3];
        end
        if (wdf_push) begin
            wdat_mem[wwp_q[FIFO_LOG2-1:0]] <= app_wdf_data_i;
            wmsk_mem[wwp_q[FIFO_LOG2-1:0]] <= app_wdf_mask_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (exec_wr) begin
            for (int b = 0; b < MW; b++) begin
                if (!wmsk_mem[wrp_q[FIFO_LOG2-1:0]][b])
                    ram[head_idx][b*8 +: 8] <= wdat_mem[wrp_q[FIFO_LOG2-1:0]][b*8 +: 8];
            end
        end
    end

    assign app_rd_data_o         = dat_pipe_q[RD_LAT];
    assign app_rd_data_valid_o   = vld_pipe_q[RD_LAT];
    assign app_rd_data_end_o     = vld_pipe_q[RD_LAT];
    assign init_calib_complete_o = calib_q;
endmodule

// File: tb/tb_ui_bram_responder.sv
module tb_ui_bram_responder;
    localparam int DW = 128, AW = 27, MEM_LOG2 = 10, RD_LAT = 2, FIFO_LOG2 = 2, INIT_CYC = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AW-1:0]   app_addr = '0;
    logic [2:0]      app_cmd = '0;
    logic            app_en = 1'b0;
    logic [DW-1:0]   wdf_data = '0;
    logic [DW/8-1:0] wdf_mask = '0;
    logic            wdf_wren = 1'b0;
    logic            wdf_end = 1'b0;
    logic [DW-1:0]   rd_data;
    logic            rd_valid, rd_end, app_rdy, wdf_rdy, calib;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ui_bram_responder #(
        .DW(DW), .AW(AW), .MEM_LOG2(MEM_LOG2), .RD_LAT(RD_LAT),
        .FIFO_LOG2(FIFO_LOG2), .INIT_CYC(INIT_CYC)
    ) dut (
        .clk_i(clk), .async_rst_i(rst),
        .app_addr_i(app_addr), .app_cmd_i(app_cmd), .app_en_i(app_en),
        .app_wdf_data_i(wdf_data), .app_wdf_mask_i(wdf_mask),
        .app_wdf_wren_i(wdf_wren), .app_wdf_end_i(wdf_end),
        .app_rd_data_o(rd_data), .app_rd_data_valid_o(rd_valid),
        .app_rd_data_end_o(rd_end), .app_rdy_o(app_rdy),
        .app_wdf_rdy_o(wdf_rdy), .init_calib_complete_o(calib)
    );

    typedef struct {
        int            op;    // 0 write, 1 read-and-check, 2 raw command
        logic [2:0]    cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [15:0]   mask;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(int op, logic [2:0] c, logic [AW-1:0] a,
                                logic [DW-1:0] d, logic [15:0] m, logic [DW-1:0] e);
        vec_t v;
        v.op = op; v.cmd = c; v.addr = a; v.data = d; v.mask = m; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic [2:0] c, input logic [AW-1:0] a);
        int n = 0;
        while (!app_rdy && n < 100) begin tick(); n++; end
        if (!app_rdy) begin
            checks++; errors++;
            $display("FAIL cmd_rdy_timeout actual=0 required=1");
        end
        app_cmd = c; app_addr = a; app_en = 1'b1;
        tick();
        app_en = 1'b0;
    endtask

    task automatic do_wd(input logic [DW-1:0] d, input logic [15:0] m);
        int n = 0;
        while (!wdf_rdy && n < 100) begin tick(); n++; end
        if (!wdf_rdy) begin
            checks++; errors++;
            $display("FAIL wdf_rdy_timeout actual=0 required=1");
        end
        wdf_data = d; wdf_mask = m; wdf_wren = 1'b1; wdf_end = 1'b1;
        tick();
        wdf_wren = 1'b0; wdf_end = 1'b0;
    endtask

    // Issue a read on an idle engine and check latency, data, end and pulse width
    task automatic read_chk(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        int n = 0;
        do_cmd(3'b001, a);
        do begin tick(); n++; end while (!rd_valid && n < 20);
        chk({name, "_lat"}, DW'(n), DW'(RD_LAT));
        chk({name, "_data"}, rd_data, exp);
        chk({name, "_end"}, DW'(rd_end), DW'(1));
        tick();
        chk({name, "_pulse"}, DW'(rd_valid), DW'(0));
    endtask

    task automatic wait_calib(input string name);
        int n = 0;
        while (!(app_rdy | wdf_rdy | calib) && n < 40) begin tick(); n++; end
        chk({name, "_cyc"}, DW'(n), DW'(INIT_CYC));
        chk({name, "_all"}, DW'({app_rdy, wdf_rdy, calib}), DW'(3'b111));
    endtask

    localparam logic [DW-1:0] D0   = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [DW-1:0] C0   = 128'hCAFEBABE_DEADBEEF_13579BDF_2468ACE0;
    localparam logic [DW-1:0] ONES = {DW{1'b1}};

    initial begin
        logic [DW-1:0] bd;
        logic seen;

        tbl[0]  = mk(0, 3'b000, 27'h18,   D0, 16'h0000, '0);
        tbl[1]  = mk(1, 3'b001, 27'h18,   '0, 16'h0000, D0);
        tbl[2]  = mk(0, 3'b000, 27'h20,   ONES, 16'h0000, '0);
        tbl[3]  = mk(0, 3'b000, 27'h20,   128'h11111111_11111111_11111111_1111115A, 16'hFFFE, '0);
        tbl[4]  = mk(1, 3'b001, 27'h20,   '0, 16'h0000, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF5A);
        tbl[5]  = mk(0, 3'b000, 27'h0,    C0, 16'h0000, '0);
        tbl[6]  = mk(1, 3'b001, 27'h2000, '0, 16'h0000, C0);
        tbl[7]  = mk(1, 3'b001, 27'h0,    '0, 16'h0000, C0);
        tbl[8]  = mk(0, 3'b000, 27'h28,   '0, 16'h0000, '0);
        tbl[9]  = mk(0, 3'b000, 27'h28,   ONES, 16'h00FF, '0);
        tbl[10] = mk(1, 3'b001, 27'h28,   '0, 16'h0000, 128'hFFFFFFFF_FFFFFFFF_00000000_00000000);
        tbl[11] = mk(0, 3'b000, 27'h2028, 128'hAB000000_00000000_00000000_00000000, 16'h7FFF, '0);
        tbl[12] = mk(1, 3'b001, 27'h28,   '0, 16'h0000, 128'hABFFFFFF_FFFFFFFF_00000000_00000000);
        tbl[13] = mk(2, 3'b111, 27'h18,   '0, 16'h0000, '0);
        tbl[14] = mk(1, 3'b001, 27'h18,   '0, 16'h0000, D0);

        // Reset state and init counter
        tick(); tick();
        chk("reset_outs", {rd_data[DW-6:0], rd_valid, rd_end, app_rdy, wdf_rdy, calib}, '0);
        rst = 1'b0;
        wait_calib("calib");

        // Table: writes send data first then command; reads follow the
        // preceding write on the very next cycle, exercising read-after-write
        for (int i = 0; i < 15; i++) begin
            case (tbl[i].op)
                0: begin do_wd(tbl[i].data, tbl[i].mask); do_cmd(3'b000, tbl[i].addr); end
                1: read_chk($sformatf("vec%0d", i), tbl[i].addr, tbl[i].exp);
                default: do_cmd(tbl[i].cmd, tbl[i].addr);
            endcase
        end

        // Four write commands with no data: command FIFO fills, writes stall
        for (int i = 0; i < 4; i++) do_cmd(3'b000, AW'(27'h100 + 8 * i));
        chk("cmd_full_rdy", DW'(app_rdy), DW'(0));
        chk("cmd_full_wdf_rdy", DW'(wdf_rdy), DW'(1));
        for (int i = 0; i < 4; i++) begin
            bd = {4{32'hBEEF0000 | 32'(i)}};
            do_wd(bd, 16'h0000);
        end
        chk("cmd_drain_rdy", DW'(app_rdy), DW'(1));
        for (int i = 0; i < 4; i++) begin
            bd = {4{32'hBEEF0000 | 32'(i)}};
            read_chk($sformatf("late%0d", i), AW'(27'h100 + 8 * i), bd);
        end

        // Reset with two reads outstanding and a stray write beat queued
        do_wd({32{4'h5}}, 16'h0000);
        do_cmd(3'b001, 27'h18);
        do_cmd(3'b001, 27'h20);
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            seen |= rd_valid;
            tick();
        end
        chk("rst_outs", DW'({rd_valid, app_rdy, wdf_rdy, calib}), DW'(0));
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            seen |= rd_valid;
            tick();
        end
        chk("rst_no_rd", DW'(seen), DW'(0));
        // calib restarts: 8 cycles already elapsed since release
        begin
            int n = 8;
            while (!calib && n < 40) begin tick(); n++; end
            chk("recal_cyc", DW'(n), DW'(INIT_CYC));
        end
        // Command before data: must pair with this beat, not the flushed stray
        do_cmd(3'b000, 27'h40);
        do_wd(128'h0F0E0D0C_0B0A0908_07060504_03020100, 16'h0000);
        read_chk("post_rst", 27'h40, 128'h0F0E0D0C_0B0A0908_07060504_03020100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
